uart_mem_bridge: RTL and testbench

//  Parametrised bridge between the UART command decoder and word-addressed SRAM; replaces the fixed 32b/15b top FSM.

---
 rtl/uart_bridge_pkg.sv | 37 +++
 rtl/bridge_rd_delay.sv | 31 +++
 rtl/uart_mem_bridge.sv | 180 ++++++++++++++++++
 tb/tb_uart_mem_bridge.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART command bridge: opcodes, status codes,
// FSM state encoding and small opcode classification helpers.
package uart_bridge_pkg;

    localparam logic [7:0] OP_WRITE      = 8'h00;
    localparam logic [7:0] OP_READ       = 8'h01;
    localparam logic [7:0] OP_BURST_READ = 8'h02;
    localparam logic [7:0] OP_FILL       = 8'h03;

    // 0x01..0x03 pass the decoder error code through unchanged
    localparam logic [7:0] ST_OK     = 8'h00;
    localparam logic [7:0] ST_DEC_E1 = 8'h01;
    localparam logic [7:0] ST_DEC_E2 = 8'h02;
    localparam logic [7:0] ST_DEC_E3 = 8'h03;
    localparam logic [7:0] ST_BAD_OP = 8'h04;
    localparam logic [7:0] ST_RANGE  = 8'h05;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WRITE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_SEND,
        S_STATUS
    } state_t;

    function automatic logic is_write_op(input logic [7:0] op);
        return (op == OP_WRITE) || (op == OP_FILL);
    endfunction

    // Opcodes whose length field is honoured; the rest move exactly one word
    function automatic logic is_len_op(input logic [7:0] op);
        return (op == OP_BURST_READ) || (op == OP_FILL);
    endfunction

endpackage

// File: rtl/bridge_rd_delay.sv
// Read-latency tracker: delays the memory read strobe by READ_LAT cycles so
// the bridge knows exactly which cycle mem_rdata is valid.
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears in-flight strobes)
//   rd_strobe  mem_en && !mem_we from the bridge
//   capture    high in the cycle mem_rdata belongs to the strobed read
module bridge_rd_delay #(
    parameter int READ_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic rd_strobe,
    output logic capture
);

    logic [READ_LAT:1] vld_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_strobe;
            for (int i = 2; i <= READ_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign capture = vld_pipe[READ_LAT];

endmodule

// File: rtl/uart_mem_bridge.sv
// Bridge between the UART command decoder and a word-addressed SRAM.
// Executes WRITE / READ / BURST_READ / FILL, range-checks every command before
// touching memory, and returns read words or status bytes over a valid/ready
// handshake so nothing is lost while the transmitter is busy.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (ready only in IDLE)
//   cmd_opcode/addr/data/len/error  decoded command fields
//   mem_en/we/addr/wdata/rdata   SRAM port, one strobe per word
//   tx_valid/tx_ready            response handshake toward word_to_byte_tx
//   tx_mode/tx_byte/tx_word      response payload (0 byte, 1 word)
//   busy                         high whenever not IDLE
module uart_mem_bridge
    import uart_bridge_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 15,
    parameter int LEN_W      = 8,
    parameter int MEM_DEPTH  = 2**ADDR_W,
    parameter int READ_LAT   = 1,
    parameter int ACK_WRITES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_opcode,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [1:0]        cmd_error,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_mode,
    output logic [7:0]        tx_byte,
    output logic [DATA_W-1:0] tx_word,
    output logic              busy
);

    // End address is computed wide enough that addr+len can never wrap
    localparam int            CW        = ADDR_W + LEN_W + 1;
    localparam logic [CW-1:0] LAST_ADDR = CW'(MEM_DEPTH - 1);

    state_t            state, state_nx;
    logic [7:0]        op_q, status_q, check_status;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q, word_q;
    logic [LEN_W-1:0]  len_q, rem_q, len_eff;
    logic [1:0]        err_q;
    logic [CW-1:0]     end_addr;
    logic              last_word, capture;

    assign len_eff   = (is_len_op(op_q) && len_q != '0) ? len_q : LEN_W'(1);
    assign end_addr  = CW'(addr_q) + CW'(len_eff) - CW'(1);
    assign last_word = (rem_q == LEN_W'(1));

    // Decoder error beats bad opcode beats range violation
    always_comb begin
        check_status = ST_OK;
        if (err_q != 2'd0)
            check_status = {6'd0, err_q};
        else if (op_q > OP_FILL)
            check_status = ST_BAD_OP;
        else if (end_addr > LAST_ADDR)
            check_status = ST_RANGE;
    end

    bridge_rd_delay #(.READ_LAT(READ_LAT)) u_rd_delay (
        .clk      (clk),
        .rst      (rst),
        .rd_strobe(mem_en && !mem_we),
        .capture  (capture)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        tx_valid  = 1'b0;
        tx_mode   = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy      = 1'b0;
                cmd_ready = !rst;
                if (cmd_valid) state_nx = S_CHECK;
            end
            S_CHECK: begin
                if (check_status != ST_OK)  state_nx = S_STATUS;
                else if (is_write_op(op_q)) state_nx = S_WRITE;
                else                        state_nx = S_RD_ISSUE;
            end
            S_WRITE: begin
                mem_en = 1'b1;
                mem_we = 1'b1;
                if (last_word) state_nx = (ACK_WRITES != 0) ? S_STATUS : S_IDLE;
            end
            S_RD_ISSUE: begin
                mem_en   = 1'b1;
                state_nx = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (capture) state_nx = S_RD_SEND;
            end
            S_RD_SEND: begin
                tx_valid = 1'b1;
                tx_mode  = 1'b1;
                if (tx_ready) state_nx = last_word ? S_IDLE : S_RD_ISSUE;
            end
            S_STATUS: begin
                tx_valid = 1'b1;
                if (tx_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            len_q    <= '0;
            err_q    <= '0;
            rem_q    <= '0;
            status_q <= '0;
            word_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= cmd_opcode;
                        addr_q <= cmd_addr;
                        data_q <= cmd_data;
                        len_q  <= cmd_len;
                        err_q  <= cmd_error;
                    end
                end
                S_CHECK: begin
                    rem_q    <= len_eff;
                    status_q <= check_status;
                end
                S_WRITE: begin
                    // Hold the address on the last word so it never steps past the end
                    if (!last_word) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        rem_q  <= rem_q - LEN_W'(1);
                    end
                end
                S_RD_WAIT: begin
                    if (capture) word_q <= mem_rdata;
                end
                S_RD_SEND: begin
                    if (tx_ready && !last_word) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        rem_q  <= rem_q - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;
    assign tx_byte   = status_q;
    assign tx_word   = word_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Self-checking bench for uart_mem_bridge: table of commands with expected
// status / access counts, scoreboard queues for memory accesses and responses,
// plus hand-written sequences for reset, latency and back-to-back commands.
module tb_uart_mem_bridge;
    import uart_bridge_pkg::*;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 15;
    localparam int LEN_W    = 8;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int READ_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [7:0]        cmd_opcode = '0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [1:0]        cmd_error = '0;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              tx_valid;
    logic              tx_ready = 1'b0;
    logic              tx_mode;
    logic [7:0]        tx_byte;
    logic [DATA_W-1:0] tx_word;
    logic              busy;

    always #5 clk = ~clk;

    uart_mem_bridge #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MEM_DEPTH(DEPTH),
        .READ_LAT(READ_LAT), .ACK_WRITES(1)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len), .cmd_error(cmd_error),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_mode(tx_mode),
        .tx_byte(tx_byte), .tx_word(tx_word), .busy(busy)
    );

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } acc_t;

    typedef struct packed {
        logic              mode;
        logic [DATA_W-1:0] val;
    } rsp_t;

    // exp_st = 8'hFF: the command answers with exp_n read words, no status byte
    typedef struct {
        logic [7:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  len;
        logic [1:0]        err;
        int                stall;
        logic [7:0]        exp_st;
        int                exp_n;
    } vec_t;

    logic [DATA_W-1:0] bmem    [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] rd_pipe [READ_LAT];
    assign mem_rdata = rd_pipe[READ_LAT-1];

    acc_t acc_q[$];
    rsp_t rsp_q[$];
    vec_t vecs[$];

    int tests = 0, fails = 0;
    int cyc = 0, stall = 0, wait_cnt = 0, hs_count = 0;
    logic              prev_hold = 1'b0, prev_mode = 1'b0;
    logic [DATA_W-1:0] prev_val = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endtask

    function automatic logic [DATA_W-1:0] pat(input int a);
        return 32'hC0DE_0000 ^ (a * 32'h0001_0003);
    endfunction

    // SRAM model: write on the strobe edge, read data valid READ_LAT cycles later
    task automatic mem_loop();
        forever begin
            @(posedge clk);
            cyc <= cyc + 1;
            if (mem_en && mem_we) bmem[mem_addr] <= mem_wdata;
            rd_pipe[0] <= (mem_en && !mem_we) ? bmem[mem_addr] : 32'hBAD0_BAD0;
            for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    endtask

    // Output monitor at the falling edge: scoreboard pops, hold checks, tx_ready pacing
    task automatic monitor_loop();
        acc_t a;
        rsp_t r;
        logic [DATA_W-1:0] cur;
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_ready  = 1'b0;
                prev_hold = 1'b0;
                wait_cnt  = 0;
            end else begin
                cur = tx_mode ? tx_word : {{(DATA_W-8){1'b0}}, tx_byte};
                if (mem_en) begin
                    if (acc_q.size() == 0) flag("unexpected_mem_en", {mem_we, mem_addr});
                    else begin
                        a = acc_q.pop_front();
                        check("mem_we", mem_we, a.we);
                        check("mem_addr", mem_addr, a.addr);
                        if (a.we) check("mem_wdata", mem_wdata, a.data);
                    end
                end
                if (prev_hold) begin
                    check("tx_hold_valid", tx_valid, 1'b1);
                    check("tx_hold_payload", {tx_mode, cur}, {prev_mode, prev_val});
                end
                if (tx_valid) begin
                    if (wait_cnt >= stall) begin tx_ready = 1'b1; wait_cnt = 0; end
                    else begin tx_ready = 1'b0; wait_cnt++; end
                end else begin
                    tx_ready = 1'($urandom_range(0, 1));
                    wait_cnt = 0;
                end
                if (tx_valid && tx_ready) begin
                    hs_count++;
                    if (rsp_q.size() == 0) flag("unexpected_tx", {tx_mode, cur});
                    else begin
                        r = rsp_q.pop_front();
                        check("tx_mode", tx_mode, r.mode);
                        check("tx_payload", cur, r.val);
                    end
                end
                prev_hold = tx_valid && !tx_ready;
                prev_mode = tx_mode;
                prev_val  = cur;
            end
        end
    endtask

    task automatic push_exp(input vec_t v);
        logic [ADDR_W-1:0] a;
        logic w;
        w = (v.op == OP_WRITE) || (v.op == OP_FILL);
        for (int i = 0; i < v.exp_n; i++) begin
            a = v.addr + ADDR_W'(i);
            acc_q.push_back('{we: w, addr: a, data: v.data});
            if (w) ref_mem[a] = v.data;
            else   rsp_q.push_back('{mode: 1'b1, val: ref_mem[a]});
        end
        if (v.exp_st != 8'hFF) rsp_q.push_back('{mode: 1'b0, val: DATA_W'(v.exp_st)});
    endtask

    // Entered and left at posedge+1; t_acc is the cycle the command was accepted
    task automatic send_cmd(input vec_t v, output int t_acc);
        int n;
        cmd_opcode = v.op;  cmd_addr = v.addr;  cmd_data = v.data;
        cmd_len    = v.len; cmd_error = v.err;  cmd_valid = 1'b1;
        n = 0;
        t_acc = -1;
        while (n < 200) begin
            @(negedge clk);
            if (cmd_ready) begin t_acc = cyc; break; end
            n++;
        end
        if (t_acc < 0) flag("cmd_accept_timeout", 64'(n));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (n < 600) begin
            @(negedge clk);
            if (!busy && acc_q.size() == 0 && rsp_q.size() == 0) break;
            n++;
        end
        if (n >= 600) flag(name, 64'(rsp_q.size()));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_acc, t_mem, t_tx, n_acc, hs0;
        vec_t v;

        for (int i = 0; i < DEPTH; i++) begin
            bmem[i]    = pat(i);
            ref_mem[i] = pat(i);
        end
        fork
            mem_loop();
            monitor_loop();
        join_none

        //           op             addr       data          len    err stall exp_st exp_n
        vecs.push_back('{OP_WRITE,      15'h0010, 32'hDEADBEEF, 8'd0,   2'd0, 0, 8'h00, 1});
        vecs.push_back('{OP_READ,       15'h0010, 32'h0,        8'd0,   2'd0, 2, 8'hFF, 1});
        vecs.push_back('{OP_FILL,       15'h7FFE, 32'h5A5A5A5A, 8'd2,   2'd0, 1, 8'h00, 2});
        vecs.push_back('{OP_FILL,       15'h7FFE, 32'h5A5A5A5A, 8'd3,   2'd0, 0, 8'h05, 0});
        vecs.push_back('{OP_READ,       15'h0020, 32'h0,        8'd0,   2'd2, 0, 8'h02, 0});
        vecs.push_back('{8'h07,         15'h0020, 32'h0,        8'd0,   2'd0, 0, 8'h04, 0});
        vecs.push_back('{8'h07,         15'h0020, 32'h0,        8'd0,   2'd1, 3, 8'h01, 0});
        vecs.push_back('{OP_FILL,       15'h7FFE, 32'h0,        8'd9,   2'd3, 0, 8'h03, 0});
        vecs.push_back('{OP_BURST_READ, 15'h7FFE, 32'h0,        8'd2,   2'd0, 0, 8'hFF, 2});
        vecs.push_back('{OP_BURST_READ, 15'h0100, 32'h0,        8'd3,   2'd0, 5, 8'hFF, 3});
        vecs.push_back('{OP_FILL,       15'h0200, 32'h12345678, 8'd0,   2'd0, 0, 8'h00, 1});
        vecs.push_back('{OP_BURST_READ, 15'h0200, 32'h0,        8'd0,   2'd0, 1, 8'hFF, 1});
        vecs.push_back('{OP_WRITE,      15'h7FFF, 32'hCAFEF00D, 8'd9,   2'd0, 0, 8'h00, 1});
        vecs.push_back('{OP_READ,       15'h7FFF, 32'h0,        8'd200, 2'd0, 4, 8'hFF, 1});
        vecs.push_back('{OP_BURST_READ, 15'h7FF0, 32'h0,        8'h20,  2'd0, 0, 8'h05, 0});

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_word", tx_word, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;

        foreach (vecs[k]) begin
            stall = vecs[k].stall;
            push_exp(vecs[k]);
            send_cmd(vecs[k], t_acc);
            wait_done($sformatf("vec%0d_timeout", k));
        end

        // Minimum read latency: strobe 2 cycles after accept, word READ_LAT+1 later
        stall = 0;
        v = '{OP_READ, 15'h0010, 32'h0, 8'd0, 2'd0, 0, 8'hFF, 1};
        push_exp(v);
        send_cmd(v, t_acc);
        t_mem = -1;
        t_tx  = -1;
        for (int n = 0; n < 50 && t_tx < 0; n++) begin
            @(negedge clk);
            if (mem_en && t_mem < 0) t_mem = cyc;
            if (tx_valid) t_tx = cyc;
        end
        check("lat_mem_en", 64'(t_mem - t_acc), 64'd2);
        check("lat_tx_valid", 64'(t_tx - t_acc), 64'(READ_LAT + 3));
        @(posedge clk); #1;
        wait_done("lat_timeout");

        // cmd_valid held high across two READs
        stall = 3;
        v = '{OP_READ, 15'h0010, 32'h0, 8'd0, 2'd0, 3, 8'hFF, 1};
        push_exp(v);
        push_exp(v);
        cmd_opcode = v.op; cmd_addr = v.addr; cmd_len = v.len; cmd_error = v.err;
        cmd_valid = 1'b1;
        n_acc = 0;
        hs0 = 0;
        for (int n = 0; n < 100 && n_acc < 2; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                n_acc++;
                if (n_acc == 1) hs0 = hs_count;
                else check("b2b_second_after_handshake", 64'(hs_count - hs0), 64'd1);
            end
        end
        check("b2b_accepts", 64'(n_acc), 64'd2);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_done("b2b_timeout");

        // Reset while a burst word waits in RD_SEND
        stall = 1000;
        v = '{OP_BURST_READ, 15'h0300, 32'h0, 8'd4, 2'd0, 1000, 8'hFF, 4};
        push_exp(v);
        send_cmd(v, t_acc);
        t_tx = -1;
        for (int n = 0; n < 50 && t_tx < 0; n++) begin
            @(negedge clk);
            if (tx_valid) t_tx = cyc;
        end
        check("abort_reached_send", 64'(t_tx >= 0), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        acc_q.delete();
        rsp_q.delete();
        @(negedge clk);
        @(negedge clk);
        check("abort_tx_valid", tx_valid, 1'b0);
        check("abort_cmd_ready", cmd_ready, 1'b0);
        check("abort_mem_en", mem_en, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        stall = 0;
        @(negedge clk);
        check("abort_release_cmd_ready", cmd_ready, 1'b1);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check("abort_no_mem_en", mem_en, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
